ifid_stage: RTL and testbench
=============================

IFID_STAGE -- requirements
Module: ifid_stage

Interface
REQ-001 clk  input  1  rising-edge clock; one clock; all state updates on this edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 inNextPC  input  16  PC+2 of the fetched instruction.
REQ-004 inInstr  input  16  fetched instruction word.
REQ-005 instr_valid  input  1  inInstr/inNextPC valid this cycle; ignored when fetch_ready=0.
REQ-006 stall  input  1  hazard unit holds the ID stage contents.
REQ-007 flush  input  1  taken branch/jump resolved downstream; squash stage contents.
REQ-008 en  input  1  global pipeline enable; 0 freezes all state.
REQ-009 outNextPC  output  16  PC+2 presented to ID.
REQ-010 outInstr  output  16  instruction presented to ID.
REQ-011 out_valid  output  1  outInstr is a real (non-bubble) instruction.
REQ-012 fetch_ready  output  1  fetch may present a new instruction and advance PC.
REQ-013 halted  output  1  a HALT has entered ID; fetch is shut off.

Function
REQ-014 NOP encoding is 16'h0800; HALT is any word with instr[15:11]=5'b00000.
REQ-015 Storage: main register {PC, instr, valid} drives outputs; one skid register {PC, instr} of identical width.
REQ-016 States: EMPTY (main invalid), FULL (main valid, skid empty), SKID (main and skid valid), HALTED.
REQ-017 fetch_ready = en & (flush | state==EMPTY | state==FULL); combinational, no added latency.
REQ-018 en=0: no register or state changes, regardless of flush, stall or instr_valid.
REQ-019 Priority when en=1: flush over stall over normal advance.
REQ-020 flush: main <= {16'h0000, 16'h0800, 0}, skid discarded, state -> EMPTY (from any state, HALTED included); instr_valid same cycle discarded.
REQ-021 Advance (stall=0), EMPTY/FULL: instr_valid=1 -> main <= input, valid=1, state FULL, or HALTED if input is HALT; instr_valid=0 -> main <= NOP, valid=0, state EMPTY.
REQ-022 Advance, SKID: main <= skid, valid=1, skid emptied, state FULL, or HALTED if skid word is HALT.
REQ-023 Advance, HALTED: main <= NOP, valid=0, outNextPC held, state stays HALTED.
REQ-024 Stall, EMPTY: instr_valid=1 -> main loaded as REQ-021 (bubble filled); else hold.
REQ-025 Stall, FULL: instr_valid=1 -> skid <= input, state SKID, main held; else hold.
REQ-026 Stall, SKID or HALTED: all contents held.
REQ-027 HALT captured into skid does not assert halted until it moves into main.
REQ-028 Latency: instruction accepted at edge N appears on outputs after edge N (one cycle) when not stalled; instruction order never changes; no instruction dropped or duplicated except by flush.
REQ-029 halted = (state==HALTED); exits only via flush or rst.

Reset
REQ-030 On rst assertion, asynchronously: outInstr=16'h0800, outNextPC=16'h0000, out_valid=0, skid empty, state EMPTY, halted=0.
REQ-031 During and after reset, fetch_ready = en.
REQ-032 Reset mid-SKID or mid-HALTED discards all held instructions.

Verification
REQ-033 Stream: en=1, instr_valid=1, words 0x4001/PC 0x0002, 0x4102/0x0004 on consecutive cycles -> outputs 0x4001/0x0002 then 0x4102/0x0004, out_valid=1, fetch_ready=1 throughout.
REQ-034 Skid: FULL with 0x4001; stall=1 while 0x4102 arrives -> main holds 0x4001, state SKID, fetch_ready=0; stall drops -> 0x4102 out next cycle, fetch_ready=1.
REQ-035 Halt: 0x0000 accepted -> next cycle outInstr=0x0000, halted=1, fetch_ready=0; following cycle outInstr=0x0800, out_valid=0; instr_valid pulses ignored.
REQ-036 Flush priority: SKID state, flush=1 with stall=1 and instr_valid=1 -> next cycle outInstr=0x0800, out_valid=0, state EMPTY, fetch_ready=1; HALTED + flush -> halted=0.
REQ-037 Freeze/reset: en=0 with flush=1 and instr_valid=1 -> outputs unchanged, fetch_ready=0; rst asserted mid-cycle in SKID -> outputs 0x0800/0x0000/valid 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/ifid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, stall/flush control
// and HALT detection that shuts off fetch once a HALT reaches ID.
module ifid_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inNextPC,
    input  logic [15:0] inInstr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        en,
    output logic [15:0] outNextPC,
    output logic [15:0] outInstr,
    output logic        out_valid,
    output logic        fetch_ready,
    output logic        halted
);

    localparam int unsigned W   = 16;
    localparam logic [W-1:0] NOP = 16'h0800;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_SKID   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e         state_q;
    logic [W-1:0]   main_pc_q;
    logic [W-1:0]   main_instr_q;
    logic           main_valid_q;
    logic [W-1:0]   skid_pc_q;
    logic [W-1:0]   skid_instr_q;

    logic in_is_halt;
    logic skid_is_halt;

    assign in_is_halt   = (inInstr[15:11] == 5'b00000);
    assign skid_is_halt = (skid_instr_q[15:11] == 5'b00000);

    // Fetch may advance only when the stage can absorb a word next edge.
    assign fetch_ready = en & (flush | (state_q == ST_EMPTY) | (state_q == ST_FULL));
    assign halted      = (state_q == ST_HALTED);

    assign outNextPC = main_pc_q;
    assign outInstr  = main_instr_q;
    assign out_valid = main_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= NOP;
            main_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP;
        end else if (en) begin
            if (flush) begin
                state_q      <= ST_EMPTY;
                main_pc_q    <= '0;
                main_instr_q <= NOP;
                main_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_EMPTY, ST_FULL: begin
                        if (stall && state_q == ST_FULL) begin
                            // Downstream holds: park the incoming word in skid.
                            if (instr_valid) begin
                                skid_pc_q    <= inNextPC;
                                skid_instr_q <= inInstr;
                                state_q      <= ST_SKID;
                            end
                        end else if (instr_valid) begin
                            main_pc_q    <= inNextPC;
                            main_instr_q <= inInstr;
                            main_valid_q <= 1'b1;
                            state_q      <= in_is_halt ? ST_HALTED : ST_FULL;
                        end else if (!stall) begin
                            main_instr_q <= NOP;
                            main_valid_q <= 1'b0;
                            state_q      <= ST_EMPTY;
                        end
                    end
                    ST_SKID: begin
                        if (!stall) begin
                            main_pc_q    <= skid_pc_q;
                            main_instr_q <= skid_instr_q;
                            main_valid_q <= 1'b1;
                            state_q      <= skid_is_halt ? ST_HALTED : ST_FULL;
                        end
                    end
                    ST_HALTED: begin
                        // HALT leaves ID as a bubble; PC is kept for debug visibility.
                        if (!stall) begin
                            main_instr_q <= NOP;
                            main_valid_q <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifid_stage.sv
// Directed self-checking bench for ifid_stage.
module tb_ifid_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inNextPC;
    logic [15:0] inInstr;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic        en;
    logic [15:0] outNextPC;
    logic [15:0] outInstr;
    logic        out_valid;
    logic        fetch_ready;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    ifid_stage dut (
        .clk        (clk),
        .rst        (rst),
        .inNextPC   (inNextPC),
        .inInstr    (inInstr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .flush      (flush),
        .en         (en),
        .outNextPC  (outNextPC),
        .outInstr   (outInstr),
        .out_valid  (out_valid),
        .fetch_ready(fetch_ready),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
        instr_valid = v;
        inInstr     = instr;
        inNextPC    = pc;
    endtask

    task automatic check_out(input string tag, input logic [15:0] instr,
                             input logic [15:0] pc, input logic v);
        check({tag, ".instr"}, 32'(outInstr), 32'(instr));
        check({tag, ".pc"},    32'(outNextPC), 32'(pc));
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        #2;
        check_out("reset", 16'h0800, 16'h0000, 1'b0);
        check("reset.halted", 32'(halted), 32'd0);
        check("reset.ready_en1", 32'(fetch_ready), 32'd1);
        en = 1'b0; #1;
        check("reset.ready_en0", 32'(fetch_ready), 32'd0);
        en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Stream of two instructions
        drive(1'b1, 16'h4001, 16'h0002); #1;
        check("stream.ready0", 32'(fetch_ready), 32'd1);
        step();
        check_out("stream0", 16'h4001, 16'h0002, 1'b1);
        check("stream.ready1", 32'(fetch_ready), 32'd1);
        drive(1'b1, 16'h4102, 16'h0004);
        step();
        check_out("stream1", 16'h4102, 16'h0004, 1'b1);
        check("stream.ready2", 32'(fetch_ready), 32'd1);

        // Skid: FULL with 0x4001, then stall while 0x4102 arrives
        drive(1'b1, 16'h4001, 16'h0002);
        step();
        stall = 1'b1;
        drive(1'b1, 16'h4102, 16'h0004);
        step();
        check_out("skid.hold", 16'h4001, 16'h0002, 1'b1);
        check("skid.ready", 32'(fetch_ready), 32'd0);
        drive(1'b1, 16'h4203, 16'h0006);  // ignored: fetch not ready
        step();
        check_out("skid.hold2", 16'h4001, 16'h0002, 1'b1);
        stall = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        step();
        check_out("skid.drain", 16'h4102, 16'h0004, 1'b1);
        check("skid.ready_after", 32'(fetch_ready), 32'd1);
        step();
        check("bubble.instr", 32'(outInstr), 32'h0800);
        check("bubble.valid", 32'(out_valid), 32'd0);
        check("bubble.ready", 32'(fetch_ready), 32'd1);

        // Halt enters ID
        drive(1'b1, 16'h0000, 16'h0010);
        step();
        check_out("halt.in", 16'h0000, 16'h0010, 1'b1);
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.ready", 32'(fetch_ready), 32'd0);
        drive(1'b1, 16'h4303, 16'h0012);
        step();
        check_out("halt.bubble", 16'h0800, 16'h0010, 1'b0);
        check("halt.halted2", 32'(halted), 32'd1);
        step();
        check_out("halt.stay", 16'h0800, 16'h0010, 1'b0);
        flush = 1'b1; #1;
        check("halt.flush_ready", 32'(fetch_ready), 32'd1);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        check("halt.flush_halted", 32'(halted), 32'd0);
        check_out("halt.flush", 16'h0800, 16'h0000, 1'b0);

        // Flush beats stall and instr_valid in SKID
        drive(1'b1, 16'h4001, 16'h0002);
        step();
        stall = 1'b1;
        drive(1'b1, 16'h4102, 16'h0004);
        step();
        check("fprio.skid_ready", 32'(fetch_ready), 32'd0);
        flush = 1'b1;
        drive(1'b1, 16'h4203, 16'h0006);
        step();
        flush = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        check_out("fprio", 16'h0800, 16'h0000, 1'b0);
        check("fprio.ready", 32'(fetch_ready), 32'd1);

        // Stall in EMPTY still fills the bubble
        drive(1'b1, 16'h4404, 16'h0008);
        step();
        check_out("stall_empty", 16'h4404, 16'h0008, 1'b1);

        // HALT parked in skid does not assert halted until it reaches main
        drive(1'b1, 16'h0000, 16'h000A);
        step();
        check_out("skidhalt.hold", 16'h4404, 16'h0008, 1'b1);
        check("skidhalt.halted0", 32'(halted), 32'd0);
        stall = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        step();
        check_out("skidhalt.main", 16'h0000, 16'h000A, 1'b1);
        check("skidhalt.halted1", 32'(halted), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;

        // Freeze: en=0 ignores flush and new input
        drive(1'b1, 16'h4505, 16'h000C);
        step();
        en = 1'b0; flush = 1'b1;
        drive(1'b1, 16'h4606, 16'h000E); #1;
        check("freeze.ready", 32'(fetch_ready), 32'd0);
        step();
        check_out("freeze1", 16'h4505, 16'h000C, 1'b1);
        step();
        check_out("freeze2", 16'h4505, 16'h000C, 1'b1);
        en = 1'b1; flush = 1'b0;

        // Async reset mid-cycle while in SKID
        drive(1'b1, 16'h4606, 16'h000E);
        step();
        stall = 1'b1;
        drive(1'b1, 16'h4707, 16'h0010);
        step();
        check("rstskid.ready_pre", 32'(fetch_ready), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check_out("rstskid", 16'h0800, 16'h0000, 1'b0);
        check("rstskid.ready", 32'(fetch_ready), 32'd1);
        #1;
        rst = 1'b0;
        stall = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000);
        step();
        check_out("rstskid.after", 16'h0800, 16'h0000, 1'b0);
        check("rstskid.halted", 32'(halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
